// File: rtl/rng_pkg.sv
// Shared types, constants and the LFSR step function for the random-word arbiter.
package rng_pkg;

  typedef enum logic {StWarmup, StRun} rng_state_e;

  // Feedback taps: bits 27,23,19,18,15,11,7,4,1.
  localparam logic [31:0] LFSR_TAPS    = 32'h088C_8892;
  localparam logic [31:0] DEFAULT_SEED = 32'd11702702;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr_i, with wrap.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  logic [IdxW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = ptr_i;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
      k = (k == IdxW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter serving one LFSR word per grant, with warm-up and runtime reseed.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WARMUP  = 8,
  parameter logic [31:0] SEED    = DEFAULT_SEED
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               seed_we_i,
  input  logic [31:0]        seed_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [31:0]        rnd_o,
  output logic               busy_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rng_state_e         state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [31:0]        rnd_q, rnd_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_picker (
    .req_i(req_i),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    ack_d    = '0;
    rnd_d    = rnd_q;
    if (seed_we_i) begin
      lfsr_d  = (seed_i == '0) ? SEED : seed_i;
      cnt_d   = '0;
      state_d = StWarmup;
    end else begin
      unique case (state_q)
        StWarmup: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (cnt_q == 8'(WARMUP - 1)) begin
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StRun: begin
          if (pick_any) begin
            ack_d    = pick_gnt;
            rnd_d    = lfsr_q;
            lfsr_d   = lfsr_step(lfsr_q);
            rr_ptr_d = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
      endcase
      // An all-zero LFSR would lock up; recover from the default seed.
      if (lfsr_q == '0) lfsr_d = SEED;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StWarmup;
      lfsr_q   <= SEED;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      ack_q    <= '0;
      rnd_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      rnd_q    <= rnd_d;
    end
  end

  assign ack_o  = ack_q;
  assign rnd_o  = rnd_q;
  assign busy_o = (state_q == StWarmup);

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: expected grants are queued, monitors compare on ack.
module tb_rng_arbiter;

  localparam logic [31:0] SEED_VAL = 32'd11702702;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  req_i, req1_i;
  logic        seed_we_i, seed_we1_i;
  logic [31:0] seed_i, seed1_i;
  logic [3:0]  ack_o, ack1_o;
  logic [31:0] rnd_o, rnd1_o;
  logic        busy_o, busy1_o;

  int total = 0;
  int bad   = 0;

  logic [35:0] q0[$];
  logic [35:0] q1[$];
  logic [31:0] m_lfsr;
  logic [31:0] last_rnd;
  int          nbusy;

  always #5 clk = ~clk;

  rng_arbiter u_dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .req_i    (req_i),
    .seed_we_i(seed_we_i),
    .seed_i   (seed_i),
    .ack_o    (ack_o),
    .rnd_o    (rnd_o),
    .busy_o   (busy_o)
  );

  rng_arbiter #(
    .WARMUP(1)
  ) u_dut1 (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .req_i    (req1_i),
    .seed_we_i(seed_we1_i),
    .seed_i   (seed1_i),
    .ack_o    (ack1_o),
    .rnd_o    (rnd1_o),
    .busy_o   (busy1_o)
  );

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic fb;
    fb = s[27] ^ s[23] ^ s[19] ^ s[18] ^ s[15] ^ s[11] ^ s[7] ^ s[4] ^ s[1];
    return {s[30:0], fb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model LFSR after a reset or reseed with the default seed and 8 warm-up steps.
  task automatic model_restart();
    m_lfsr = SEED_VAL;
    repeat (8) m_lfsr = ref_step(m_lfsr);
  endtask

  task automatic expect_grant(input logic [3:0] ack);
    q0.push_back({ack, m_lfsr});
    last_rnd = m_lfsr;
    m_lfsr   = ref_step(m_lfsr);
  endtask

  // Called at a negedge; counts consecutive sampled cycles with busy_o high.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic hold_req(input logic [3:0] r, input int n);
    req_i = r;
    repeat (n) @(negedge clk);
    req_i = '0;
  endtask

  initial begin : mon0
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (!reset_i && ack_o != '0) begin
        total++;
        if ($countones(ack_o) != 1 || busy_o) begin
          bad++;
          $display("FAIL ack_shape: ack=%b busy=%b", ack_o, busy_o);
        end
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: ack=%b rnd=%0h expected none", ack_o, rnd_o);
        end else begin
          e = q0.pop_front();
          check("grant", {28'd0, ack_o, rnd_o}, {28'd0, e});
        end
      end
    end
  end

  initial begin : mon1
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (!reset_i && ack1_o != '0) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack1: ack=%b rnd=%0h expected none", ack1_o, rnd1_o);
        end else begin
          e = q1.pop_front();
          check("grant_w1", {28'd0, ack1_o, rnd1_o}, {28'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_i    = 1'b1;
    req_i      = '0;
    req1_i     = '0;
    seed_we_i  = 1'b0;
    seed_we1_i = 1'b0;
    seed_i     = '0;
    seed1_i    = '0;
    repeat (2) @(negedge clk);
    check("reset_ack", 64'(ack_o), 64'd0);
    check("reset_rnd", 64'(rnd_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd1);

    // Release reset: 8 busy cycles with no requests.
    reset_i = 1'b0;
    model_restart();
    count_busy(nbusy);
    check("warmup_len", 64'(nbusy), 64'd8);

    // WARMUP=1 instance reseeded with 1: stream 2,5,10,21,43.
    seed_we1_i = 1'b1;
    seed1_i    = 32'd1;
    req1_i     = 4'b0001;
    q1.push_back({4'b0001, 32'd2});
    q1.push_back({4'b0001, 32'd5});
    q1.push_back({4'b0001, 32'd10});
    q1.push_back({4'b0001, 32'd21});
    q1.push_back({4'b0001, 32'd43});
    @(negedge clk);
    seed_we1_i = 1'b0;
    check("w1_busy_after_seed", 64'(busy1_o), 64'd1);
    check("w1_ack_after_seed", 64'(ack1_o), 64'd0);
    repeat (6) @(negedge clk);
    req1_i = '0;

    // All four requesting from rr_ptr=0.
    expect_grant(4'b0001);
    expect_grant(4'b0010);
    expect_grant(4'b0100);
    expect_grant(4'b1000);
    expect_grant(4'b0001);
    hold_req(4'b1111, 5);

    // rr_ptr=1 with 0101: 2, 0, 2.
    expect_grant(4'b0100);
    expect_grant(4'b0001);
    expect_grant(4'b0100);
    hold_req(4'b0101, 3);
    repeat (2) @(negedge clk);
    check("idle_ack", 64'(ack_o), 64'd0);
    check("idle_rnd_hold", 64'(rnd_o), 64'(last_rnd));

    // rr_ptr=3: lone requester 3, then 0110 from ptr 0.
    expect_grant(4'b1000);
    hold_req(4'b1000, 1);
    expect_grant(4'b0010);
    expect_grant(4'b0100);
    hold_req(4'b0110, 2);

    // Reseed with zero while requester 2 waits: default-seed stream, grant after warm-up.
    seed_we_i = 1'b1;
    seed_i    = '0;
    req_i     = 4'b0100;
    model_restart();
    expect_grant(4'b0100);
    @(negedge clk);
    seed_we_i = 1'b0;
    check("reseed_no_ack", 64'(ack_o), 64'd0);
    count_busy(nbusy);
    check("reseed_warmup_len", 64'(nbusy), 64'd8);
    @(negedge clk);
    req_i = '0;

    // Reset mid-stream with requests active (rr_ptr=3 before).
    expect_grant(4'b1000);
    expect_grant(4'b0010);
    req_i = 4'b1010;
    repeat (2) @(negedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    check("midreset_ack", 64'(ack_o), 64'd0);
    check("midreset_rnd", 64'(rnd_o), 64'd0);
    check("midreset_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    reset_i = 1'b0;
    model_restart();
    expect_grant(4'b0010);
    expect_grant(4'b1000);
    count_busy(nbusy);
    check("midreset_warmup_len", 64'(nbusy), 64'd8);
    repeat (2) @(negedge clk);
    req_i = '0;

    repeat (3) @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
